// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Counter width for a given operand width, never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CNT_W     = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/fs_bit_cell.sv
// One-bit full subtractor: d = x - y - bin, with borrow-out.
module fs_bit_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial A - B - BIN, LSB first, reusing a single full-subtractor cell.
module serial_subtractor_ctrl
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sr_q, a_sr_d;
  logic [WIDTH-1:0]  b_sr_q, b_sr_d;
  logic [WIDTH-1:0]  res_sr_q, res_sr_d;
  logic              borrow_q, borrow_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              bout_q, bout_d;

  logic              d_bit, bn_bit;
  logic [WIDTH:0]    res_shift;

  fs_bit_cell u_cell (
    .x   (a_sr_q[0]),
    .y   (b_sr_q[0]),
    .bin (borrow_q),
    .d   (d_bit),
    .bout(bn_bit)
  );

  // New bit enters at the MSB so the LSB-first result ends up in place.
  assign res_shift = {d_bit, res_sr_q} >> 1;

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    borrow_d = borrow_q;
    count_d  = count_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          borrow_d = bin;
          count_d  = '0;
          state_d  = StRun;
        end else begin
          state_d  = StIdle;
        end
      end
      StRun: begin
        res_sr_d = res_shift[WIDTH-1:0];
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        borrow_d = bn_bit;
        count_d  = count_q + CntW'(1);
        if (count_q == CntW'(WIDTH - 1)) begin
          // Publish the result so it is visible for the whole DONE cycle and held after.
          diff_d  = res_shift[WIDTH-1:0];
          bout_d  = bn_bit;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      borrow_q <= 1'b0;
      count_q  <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      borrow_q <= borrow_d;
      count_q  <= count_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench: driver pushes A-B-BIN expectations, monitor checks each done pulse.
module tb_serial_subtractor_ctrl;

  localparam int unsigned W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         bin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done, bout;
  logic [W-1:0] diff;

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [W:0]  exp_q[$];
  int unsigned exp_cyc_q[$];
  logic [W:0]  held = '0;
  int          busy_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, inputs change just after the rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      if (busy) begin
        busy_run++;
      end else if (busy_run != 0) begin
        chk("busy_len", busy_run, W);
        busy_run = 0;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_done: got done=1 diff=0x%0h, expected no done (cycle %0d)",
                   diff, cyc);
        end else begin
          logic [W:0]  e;
          int unsigned c;
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          chk("result", {23'b0, bout, diff}, {23'b0, e});
          chk("latency", cyc, c);
          held = e;
        end
      end else begin
        chk("held", {23'b0, bout, diff}, {23'b0, held});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic biv,
                       input bit push);
    a     = av;
    b     = bv;
    bin   = biv;
    start = 1'b1;
    if (push) begin
      exp_q.push_back(({1'b0, av} - {1'b0, bv}) - {{W{1'b0}}, biv});
      exp_cyc_q.push_back(cyc + W + 1);
    end
    step(1);
    start = 1'b0;
  endtask

  // Leaves the driver in the first non-busy cycle (the DONE cycle).
  task automatic wait_done();
    int n = 0;
    while (busy && n < 40) begin
      step(1);
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL wait_done: busy still 1 after %0d cycles, expected 0", n);
    end
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] edges [4];
    edges[0] = 8'h00; edges[1] = 8'hFF; edges[2] = 8'h80; edges[3] = 8'h7F;
    if ($urandom_range(0, 4) == 0) return edges[$urandom_range(0, 3)];
    return W'($urandom);
  endfunction

  initial begin
    step(3);
    rst_n = 1'b1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_diff", {24'b0, diff}, 0);
    chk("rst_bout", {31'b0, bout}, 0);
    step(2);

    issue(8'h05, 8'h03, 1'b0, 1'b1);
    wait_done();
    step(2);
    issue(8'h00, 8'h01, 1'b0, 1'b1);
    wait_done();
    step(1);
    issue(8'hFF, 8'hFF, 1'b1, 1'b1);
    wait_done();
    step(2);

    // Start during RUN cycle 3 must be ignored.
    issue(8'h05, 8'h03, 1'b0, 1'b1);
    step(2);
    a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done();
    step(12);

    // Reset at RUN cycle 4 aborts the operation without a done pulse.
    issue(8'h35, 8'h12, 1'b0, 1'b0);
    step(3);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    held = '0;
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_done", {31'b0, done}, 0);
    chk("abort_diff", {24'b0, diff}, 0);
    chk("abort_bout", {31'b0, bout}, 0);
    step(15);

    // Back-to-back: start held in the DONE cycle.
    issue(8'h01, 8'h01, 1'b0, 1'b1);
    wait_done();
    issue(8'h80, 8'h7F, 1'b0, 1'b1);
    wait_done();
    step(3);

    for (int i = 0; i < 1500; i++) begin
      issue(pick(), pick(), 1'($urandom), 1'b1);
      wait_done();
      if ($urandom_range(0, 2) == 0) step($urandom_range(1, 3));
    end

    step(12);
    chk("drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
